strip_frame_buffer: RTL

STRIP_FRAME_BUFFER -- requirements
Module: strip_frame_buffer

---
 rtl/strip_frame_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/strip_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : strip_frame_buffer
// Brief    : Double-buffered LED strip frame store. The host fills the back
//            buffer; the strip driver reads the front buffer through a
//            req/rdy handshake. Committed swaps take effect at frame start.
// Revision : 1.0 - initial release
// ============================================================================
module strip_frame_buffer #(
    parameter int MAX_LEDS      = 3,
    parameter int NUM_CHANNELS  = 3,
    parameter int ADDRESS_WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    input  logic                     frame_commit,
    input  logic                     mem_req,
    input  logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_rdy,
    output logic [7:0]               mem_data,
    output logic                     swap_pending,
    output logic [7:0]               frame_count
);

    localparam int DEPTH   = MAX_LEDS * NUM_CHANNELS;
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] c_DEPTH_A = ADDRESS_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic                     r_front_sel;
    logic                     r_swap_pending;
    logic                     r_mem_rdy;
    logic [7:0]               r_mem_data;
    logic [7:0]               r_frame_count;

    logic [7:0]               r_buf0 [DEPTH];
    logic [7:0]               r_buf1 [DEPTH];

    logic                     w_wr_hit;
    logic [c_IDX_W-1:0]       w_wr_idx;
    logic                     w_latch;
    logic                     w_apply;
    logic                     w_rd_hit;
    logic [c_IDX_W-1:0]       w_rd_idx;
    logic [7:0]               w_rd_byte;

    assign w_wr_hit = wr_en && (wr_addr < c_DEPTH_A);
    assign w_wr_idx = wr_addr[c_IDX_W-1:0];

    // Buffer storage is deliberately outside reset; r_front_sel here is the
    // pre-swap value, so a write coinciding with a swap lands in the old back.
    always_ff @(posedge clk) begin
        if (w_wr_hit) begin
            if (r_front_sel) begin
                r_buf0[w_wr_idx] <= wr_data;
            end else begin
                r_buf1[w_wr_idx] <= wr_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_apply      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_req) begin
                    w_latch      = 1'b1;
                    w_apply      = r_swap_pending && (mem_addr == '0);
                    w_state_next = S_READ;
                end
            end
            S_READ:  w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_rd_hit = (r_addr < c_DEPTH_A);
    assign w_rd_idx = r_addr[c_IDX_W-1:0];

    always_comb begin
        w_rd_byte = 8'h00;
        if (w_rd_hit) begin
            w_rd_byte = r_front_sel ? r_buf1[w_rd_idx] : r_buf0[w_rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_front_sel    <= 1'b0;
            r_swap_pending <= 1'b0;
            r_mem_rdy      <= 1'b0;
            r_mem_data     <= 8'h00;
            r_frame_count  <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            // Registered pulse: high exactly during the RESP cycle.
            r_mem_rdy <= (r_state == S_READ);
            if (r_state == S_READ) begin
                r_mem_data <= w_rd_byte;
            end
            if (w_latch) begin
                r_addr <= mem_addr;
            end
            if (w_apply) begin
                r_front_sel   <= ~r_front_sel;
                r_frame_count <= r_frame_count + 8'd1;
            end
            r_swap_pending <= frame_commit | (r_swap_pending & ~w_apply);
        end
    end

    assign mem_rdy      = r_mem_rdy;
    assign mem_data     = r_mem_data;
    assign swap_pending = r_swap_pending;
    assign frame_count  = r_frame_count;

endmodule
`default_nettype wire
